// File: rtl/block_dispatcher.sv
// block_dispatcher: splits a kernel launch into fixed-size thread
// blocks, hands them to compute cores and tracks their completion.
module block_dispatcher #(
  parameter  int NUM_CORES         = 2,
  parameter  int THREADS_PER_BLOCK = 4,
  localparam int TC_W = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                thread_count,
  input  logic [NUM_CORES-1:0]      core_done,
  output logic [NUM_CORES-1:0]      core_start,
  output logic [NUM_CORES*8-1:0]    core_block_id,
  output logic [NUM_CORES*TC_W-1:0] core_thread_count,
  output logic                      busy,
  output logic                      done
);

  localparam int LOG = $clog2(THREADS_PER_BLOCK);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [7:0] MASK = 8'(THREADS_PER_BLOCK - 1);
  localparam logic [TC_W-1:0] FULL = TC_W'(THREADS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    WAIT,
    DONE
  } state_t;

  state_t state;

  logic [7:0]           tc_q;
  logic [7:0]           dispatched;
  logic [7:0]           finished;
  logic [NUM_CORES-1:0] core_busy;

  logic [7:0]           rem;
  logic [7:0]           total;
  logic [IDX_W-1:0]     pick;
  logic                 pick_ok;
  logic                 do_disp;
  logic                 last;
  logic [TC_W-1:0]      blk_cnt;
  logic [NUM_CORES-1:0] grant;
  logic [NUM_CORES-1:0] fin;
  logic [7:0]           fin_cnt;
  logic [7:0]           disp_nx;
  logic [7:0]           fin_nx;
  logic [NUM_CORES-1:0] busy_nx;

  // Ceiling division by a power of two: shift plus a partial-block bit.
  assign rem   = tc_q & MASK;
  assign total = (tc_q >> LOG) + {7'd0, |rem};

  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (!core_busy[i]) begin
        pick    = IDX_W'(i);
        pick_ok = 1'b1;
      end
    end
  end

  assign do_disp = (state == DISPATCH) && pick_ok
                   && (dispatched < total);
  assign last    = (dispatched == total - 8'd1);
  assign blk_cnt = (last && rem != 8'd0) ? TC_W'(rem) : FULL;

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (do_disp && pick == IDX_W'(i)) grant[i] = 1'b1;
    end
  end

  // Only a core that actually holds a block may retire one.
  assign fin = core_done & core_busy;

  always_comb begin
    fin_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      fin_cnt = fin_cnt + {7'd0, fin[i]};
    end
  end

  assign disp_nx = dispatched + {7'd0, do_disp};
  assign fin_nx  = finished + fin_cnt;
  assign busy_nx = (core_busy & ~fin) | grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      tc_q              <= '0;
      dispatched        <= '0;
      finished          <= '0;
      core_busy         <= '0;
      core_start        <= '0;
      core_block_id     <= '0;
      core_thread_count <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      core_start <= grant;
      unique case (state)
        IDLE: begin
          if (start) begin
            tc_q       <= thread_count;
            dispatched <= '0;
            finished   <= '0;
            core_busy  <= '0;
            if (thread_count == 8'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DISPATCH;
              busy  <= 1'b1;
            end
          end
        end
        DISPATCH, WAIT: begin
          core_busy  <= busy_nx;
          dispatched <= disp_nx;
          finished   <= fin_nx;
          for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
              core_block_id[i*8 +: 8]           <= dispatched;
              core_thread_count[i*TC_W +: TC_W] <= blk_cnt;
            end
          end
          if (state == DISPATCH) begin
            if (disp_nx == total) state <= WAIT;
          end else if (fin_nx == total) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_dispatcher.sv
// tb_block_dispatcher: vector table, directed corner cases and a
// randomized launch scoreboard for block_dispatcher.
module tb_block_dispatcher;

  localparam int NC  = 2;
  localparam int TPB = 4;
  localparam int TCW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [7:0]      thread_count = '0;
  logic [NC-1:0]   core_done = '0;
  logic [NC-1:0]   core_start;
  logic [NC*8-1:0] core_block_id;
  logic [NC*TCW-1:0] core_thread_count;
  logic            busy;
  logic            done;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  block_dispatcher #(
    .NUM_CORES(NC),
    .THREADS_PER_BLOCK(TPB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .thread_count(thread_count),
    .core_done(core_done),
    .core_start(core_start),
    .core_block_id(core_block_id),
    .core_thread_count(core_thread_count),
    .busy(busy),
    .done(done)
  );

  typedef struct packed {
    logic       st;
    logic [7:0] tc;
    logic [1:0] cd;
    logic [1:0] cs;
    logic       bz;
    logic       dn;
    logic [15:0] bid;
    logic [5:0] cnt;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Scoreboard: blocks are handed out in order, each to the lowest
  // idle core; a launch ends when every block has been retired.
  task automatic run_launch(input logic [7:0] tc, input int pct,
                            input int spur, output int ndisp);
    int total, ndone, j, cyc, ecnt, left;
    logic [NC-1:0] mbusy, cd, fin, ecs;
    bit all_done;
    total = (int'(tc) + TPB - 1) / TPB;
    ndisp = 0;
    ndone = 0;
    mbusy = '0;
    start = 1'b1;
    thread_count = tc;
    core_done = '0;
    @(negedge clk);
    chk("launch", {core_start, busy, done},
        {2'b00, tc != 8'd0, tc == 8'd0});
    all_done = (tc == 8'd0);
    cyc = 0;
    while (!all_done && cyc < 1000) begin
      cd = '0;
      for (int i = 0; i < NC; i++) begin
        if (mbusy[i] ? ($urandom_range(99) < pct)
                     : ($urandom_range(99) < spur))
          cd[i] = 1'b1;
      end
      core_done = cd;
      thread_count = 8'($urandom);
      start = ($urandom_range(3) != 0);
      @(negedge clk);
      ecs = '0;
      j = -1;
      if (ndisp < total) begin
        for (int i = NC - 1; i >= 0; i--) if (!mbusy[i]) j = i;
      end
      if (j >= 0) ecs[j] = 1'b1;
      chk("dispatch core", core_start, ecs);
      if (j >= 0) begin
        left = int'(tc) - ndisp * TPB;
        ecnt = (left < TPB) ? left : TPB;
        chk("block id", core_block_id[j*8 +: 8], ndisp);
        chk("block cnt", core_thread_count[j*TCW +: TCW], ecnt);
        ndisp++;
      end
      fin = cd & mbusy;
      for (int i = 0; i < NC; i++) ndone += int'(fin[i]);
      mbusy = (mbusy & ~fin) | ecs;
      all_done = (ndone == total);
      chk("busy/done", {busy, done}, {!all_done, all_done});
      cyc++;
    end
    if (!all_done) chk("launch timeout", ndone, total);
    start = 1'b1;
    core_done = NC'($urandom);
    thread_count = 8'd7;
    @(negedge clk);
    chk("done hold", {core_start, busy, done}, 4'b0001);
    start = 1'b0;
    core_done = '0;
    @(negedge clk);
    chk("done clear", {core_start, busy, done}, 4'b0000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [7:0] tc;
    //          st  tc     cd     cs     bz    dn    bid       cnt
    tbl[0]  = '{1'b1, 8'd10, 2'b00, 2'b00, 1'b1, 1'b0, 16'h0000, 6'h00};
    tbl[1]  = '{1'b1, 8'd99, 2'b00, 2'b01, 1'b1, 1'b0, 16'h0000, 6'h04};
    tbl[2]  = '{1'b1, 8'd99, 2'b00, 2'b10, 1'b1, 1'b0, 16'h0100, 6'h24};
    tbl[3]  = '{1'b1, 8'd99, 2'b00, 2'b00, 1'b1, 1'b0, 16'h0100, 6'h24};
    tbl[4]  = '{1'b0, 8'd99, 2'b01, 2'b00, 1'b1, 1'b0, 16'h0100, 6'h24};
    tbl[5]  = '{1'b0, 8'd99, 2'b10, 2'b01, 1'b1, 1'b0, 16'h0102, 6'h22};
    tbl[6]  = '{1'b0, 8'd99, 2'b00, 2'b00, 1'b1, 1'b0, 16'h0102, 6'h22};
    tbl[7]  = '{1'b1, 8'd99, 2'b00, 2'b00, 1'b1, 1'b0, 16'h0102, 6'h22};
    tbl[8]  = '{1'b1, 8'd99, 2'b01, 2'b00, 1'b0, 1'b1, 16'h0102, 6'h22};
    tbl[9]  = '{1'b1, 8'd99, 2'b00, 2'b00, 1'b0, 1'b1, 16'h0102, 6'h22};
    tbl[10] = '{1'b0, 8'd99, 2'b00, 2'b00, 1'b0, 1'b0, 16'h0102, 6'h22};
    tbl[11] = '{1'b0, 8'd0,  2'b00, 2'b00, 1'b0, 1'b0, 16'h0102, 6'h22};
    tbl[12] = '{1'b1, 8'd0,  2'b00, 2'b00, 1'b0, 1'b1, 16'h0102, 6'h22};
    tbl[13] = '{1'b0, 8'd0,  2'b00, 2'b00, 1'b0, 1'b0, 16'h0102, 6'h22};
    tbl[14] = '{1'b0, 8'd0,  2'b10, 2'b00, 1'b0, 1'b0, 16'h0102, 6'h22};
    tbl[15] = '{1'b1, 8'd8,  2'b00, 2'b00, 1'b1, 1'b0, 16'h0102, 6'h22};
    tbl[16] = '{1'b1, 8'd0,  2'b00, 2'b01, 1'b1, 1'b0, 16'h0100, 6'h24};
    tbl[17] = '{1'b1, 8'd0,  2'b10, 2'b10, 1'b1, 1'b0, 16'h0100, 6'h24};
    tbl[18] = '{1'b1, 8'd0,  2'b11, 2'b00, 1'b0, 1'b1, 16'h0100, 6'h24};
    tbl[19] = '{1'b1, 8'd0,  2'b11, 2'b00, 1'b0, 1'b1, 16'h0100, 6'h24};
    tbl[20] = '{1'b0, 8'd0,  2'b00, 2'b00, 1'b0, 1'b0, 16'h0100, 6'h24};
    tbl[21] = '{1'b0, 8'd0,  2'b00, 2'b00, 1'b0, 1'b0, 16'h0100, 6'h24};

    repeat (3) @(negedge clk);
    chk("in reset",
        {core_start, busy, done, core_block_id, core_thread_count}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("after reset",
        {core_start, busy, done, core_block_id, core_thread_count}, 0);

    for (int k = 0; k < 22; k++) begin
      start = tbl[k].st;
      thread_count = tbl[k].tc;
      core_done = tbl[k].cd;
      @(negedge clk);
      chk($sformatf("vec%0d", k),
          {core_start, busy, done, core_block_id, core_thread_count},
          {tbl[k].cs, tbl[k].bz, tbl[k].dn, tbl[k].bid, tbl[k].cnt});
    end

    run_launch(8'd255, 100, 0, n);
    chk("tc255 dispatches", n, 64);

    start = 1'b1;
    thread_count = 8'd12;
    core_done = '0;
    repeat (3) @(negedge clk);
    chk("mid dispatch busy", {busy, done}, 2'b10);
    #2 reset = 1'b0;
    #1 chk("async reset",
           {core_start, busy, done, core_block_id, core_thread_count}, 0);
    @(negedge clk);
    core_done = '1;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    core_done = '0;
    @(negedge clk);
    chk("late done ignored",
        {core_start, busy, done, core_block_id, core_thread_count}, 0);
    run_launch(8'd4, 100, 0, n);
    chk("relaunch dispatches", n, 1);

    for (int r = 0; r < 30; r++) begin
      tc = ($urandom_range(4) == 0) ? 8'd0 : 8'($urandom_range(60, 1));
      run_launch(tc, $urandom_range(90, 20), 10, n);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
